// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state, Gray
// conversion and the width derivations used by the top and the LUT bank.
package tts_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} tts_state_t;

  localparam int N_IN_DEF  = 3;
  localparam int N_FN_DEF  = 6;
  localparam int TBL_W     = 2 ** N_IN_DEF;
  localparam int CFG_SEL_W = (N_FN_DEF <= 1) ? 1 : $clog2(N_FN_DEF);

  function automatic int calc_tbl_w(input int n_in);
    return 2 ** n_in;
  endfunction

  function automatic int calc_sel_w(input int n_fn);
    return (n_fn <= 1) ? 1 : $clog2(n_fn);
  endfunction

  // Widest legal N_IN is 8, so one 8-bit converter serves every build.
  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Output beat stream of the sweeper: one input vector plus every channel's
// output per beat, valid/ready handshake.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3,
  parameter int N_FN = 6
);
  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_idx;
  logic [N_FN-1:0] out_val;

  modport master (output out_valid, output out_idx, output out_val, input  out_ready);
  modport slave  (input  out_valid, input  out_idx, input  out_val, output out_ready);
endinterface

// File: rtl/tts_lut_bank.sv
// N_FN truth-table registers with one write port and a combinational read of
// every channel at a shared index; a same-cycle write is forwarded to the read.
module tts_lut_bank
  import tts_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_FN = 6,
  localparam int TW  = calc_tbl_w(N_IN),
  localparam int SW  = calc_sel_w(N_FN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [SW-1:0]            sel_i,
  input  logic [TW-1:0]            tbl_i,
  input  logic [N_IN-1:0]          rd_idx_i,
  output logic [N_FN-1:0]          rd_val_o
);

  logic [N_FN-1:0][TW-1:0] tbl_q;

  for (genvar f = 0; f < N_FN; f++) begin : g_ch
    logic          hit;
    logic [TW-1:0] eff;

    // Selects >= N_FN never match any channel, so such writes are dropped.
    assign hit = we_i && (sel_i == SW'(f));
    assign eff = hit ? tbl_i : tbl_q[f];
    assign rd_val_o[f] = eff[rd_idx_i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      tbl_q[f] <= '0;
      else if (hit) tbl_q[f] <= tbl_i;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of N_FN programmable N_IN-input functions onto a
// valid/ready stream, then pulses done. Define TTS_GRAY_ORDER_EN for Gray order.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_FN = 6,
  localparam int TW  = calc_tbl_w(N_IN),
  localparam int SW  = calc_sel_w(N_FN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [SW-1:0]          cfg_sel,
  input  logic [TW-1:0]          cfg_table,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  truth_table_sweeper_if.master  stream
);

  tts_state_t      state_q;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_FN-1:0] val_q, val_d;
  logic            busy_q, valid_q, done_q;
  logic            idle;

  assign idle  = (state_q == IDLE);
  // From IDLE the next beat is vector 0; in RUN it is the successor.
  assign cnt_d = idle ? '0 : cnt_q + 1'b1;

`ifdef TTS_GRAY_ORDER_EN
  assign idx_d = N_IN'(bin2gray(8'(cnt_d)));
`else
  assign idx_d = cnt_d;
`endif

  // Writes land only in IDLE; the bypass lets a start in the same cycle see them.
  tts_lut_bank #(.N_IN(N_IN), .N_FN(N_FN)) u_lut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (cfg_we && idle),
    .sel_i    (cfg_sel),
    .tbl_i    (cfg_table),
    .rd_idx_i (idx_d),
    .rd_val_o (val_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            idx_q   <= idx_d;
            val_q   <= val_d;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (stream.out_ready) begin
            if (&cnt_q) begin
              state_q <= DONE;
              idx_q   <= '0;
              val_q   <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
              idx_q <= idx_d;
              val_q <= val_d;
            end
          end
        end
        DONE: begin
          // Abort here lands in the same place as the normal return.
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign stream.out_valid = valid_q;
  assign stream.out_idx   = idx_q;
  assign stream.out_val   = val_q;

endmodule
